// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared states and constants for the PC sequencer
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_UPDATE  = 3'd4
  } seq_state_e;

  localparam logic [31:0] DEFAULT_INITIAL_PC = 32'h0040_0000;
  localparam logic [31:0] INSTR_ALIGN_MASK   = 32'h0000_0003;
  localparam logic [31:0] PC_STEP            = 32'd4;

  // A redirect target is usable only if it is word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr & INSTR_ALIGN_MASK) != 32'd0;
  endfunction

endpackage

// File: rtl/pc_target_select.sv
// rtl/pc_target_select.sv - prioritised next-PC selection with alignment check
module pc_target_select
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_request,
  input  logic [31:0] trap_vector,
  input  logic        trap_return,
  input  logic [31:0] epc,
  output logic [31:0] target,
  output logic        misaligned,
  output logic        retire
);

  // Trap entry wins, then trap return, then branch, then fall-through; a bad
  // epc or branch target diverts to the trap vector and does not retire.
  always_comb begin
    target     = pc + PC_STEP;
    misaligned = 1'b0;
    retire     = 1'b1;
    if (trap_request) begin
      target = trap_vector;
      retire = 1'b0;
    end else if (trap_return) begin
      if (is_misaligned(epc)) begin
        target     = trap_vector;
        misaligned = 1'b1;
        retire     = 1'b0;
      end else begin
        target = epc;
      end
    end else if (branch_taken) begin
      if (is_misaligned(branch_target)) begin
        target     = trap_vector;
        misaligned = 1'b1;
        retire     = 1'b0;
      end else begin
        target = branch_target;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/issue/execute/update sequencer driving the PC
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] INITIAL_PC = DEFAULT_INITIAL_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_enable,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_request,
  input  logic [31:0] trap_vector,
  input  logic        trap_return,
  input  logic [31:0] epc,
  output logic        misaligned_fetch,
  output logic [63:0] instret
);

  seq_state_e  state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        pc_enable_q, pc_enable_d;
  logic        fetch_req_q, fetch_req_d;
  logic        misaligned_q, misaligned_d;
  logic [63:0] instret_q, instret_d;

  logic [31:0] sel_target;
  logic        sel_misaligned;
  logic        sel_retire;

  pc_target_select u_target_select (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .trap_request  (trap_request),
    .trap_vector   (trap_vector),
    .trap_return   (trap_return),
    .epc           (epc),
    .target        (sel_target),
    .misaligned    (sel_misaligned),
    .retire        (sel_retire)
  );

  // Next state plus the strobes of the state being entered, so every output is a flop.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    instr_d      = instr_q;
    valid_d      = 1'b0;
    pc_enable_d  = 1'b0;
    fetch_req_d  = 1'b0;
    misaligned_d = 1'b0;
    instret_d    = instret_q;
    case (state_q)
      ST_INIT: begin
        // First cycle out of reset arms the INITIAL_PC load; target_q already holds it.
        if (!pc_enable_q) begin
          pc_enable_d = 1'b1;
        end else begin
          state_d     = ST_FETCH;
          fetch_req_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (fetch_ack) begin
          state_d = ST_ISSUE;
          instr_d = fetch_data;
          valid_d = 1'b1;
        end else begin
          fetch_req_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (exec_done) begin
          state_d      = ST_UPDATE;
          target_d     = sel_target;
          misaligned_d = sel_misaligned;
          pc_enable_d  = 1'b1;
          if (sel_retire) begin
            instret_d = instret_q + 64'd1;
          end
        end
      end
      ST_UPDATE: begin
        state_d     = ST_FETCH;
        fetch_req_d = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and registered outputs; reset restarts from INIT and drops any pending ack.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      target_q     <= INITIAL_PC;
      instr_q      <= 32'd0;
      valid_q      <= 1'b0;
      pc_enable_q  <= 1'b0;
      fetch_req_q  <= 1'b0;
      misaligned_q <= 1'b0;
      instret_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      pc_enable_q  <= pc_enable_d;
      fetch_req_q  <= fetch_req_d;
      misaligned_q <= misaligned_d;
      instret_q    <= instret_d;
    end
  end

  assign next_pc           = target_q;
  assign pc_enable         = pc_enable_q;
  assign fetch_req         = fetch_req_q;
  assign fetch_addr        = pc;
  assign instruction       = instr_q;
  assign instruction_valid = valid_q;
  assign misaligned_fetch  = misaligned_q;
  assign instret           = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_reg;
  logic [31:0] next_pc;
  logic        pc_enable;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_request;
  logic [31:0] trap_vector;
  logic        trap_return;
  logic [31:0] epc;
  logic        misaligned_fetch;
  logic [63:0] instret;

  localparam logic [31:0] INIT_PC = 32'h0040_0000;

  pc_sequencer #(.INITIAL_PC(INIT_PC)) dut (
    .clock             (clock),
    .reset             (reset),
    .pc                (pc_reg),
    .next_pc           (next_pc),
    .pc_enable         (pc_enable),
    .fetch_req         (fetch_req),
    .fetch_addr        (fetch_addr),
    .fetch_ack         (fetch_ack),
    .fetch_data        (fetch_data),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .exec_done         (exec_done),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .trap_request      (trap_request),
    .trap_vector       (trap_vector),
    .trap_return       (trap_return),
    .epc               (epc),
    .misaligned_fetch  (misaligned_fetch),
    .instret           (instret)
  );

  always #5 clock = ~clock;

  // External PC register loaded by the sequencer's write strobe
  always @(posedge clock) begin
    if (pc_enable) pc_reg <= next_pc;
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] tgt;
    logic        mis;
    logic [63:0] ret;
  } upd_t;

  upd_t        upd_q[$];
  logic [31:0] inst_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_pc;
  logic [63:0] model_ret;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops scoreboard entries on each strobe
  logic upd_gap = 1'b0;
  logic valid_gap = 1'b0;
  upd_t mon_e;
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (upd_gap) begin
        check_eq("misaligned_width", misaligned_fetch, 0);
        check_eq("pc_enable_width", pc_enable, 0);
      end
      if (valid_gap) check_eq("valid_width", instruction_valid, 0);
      upd_gap   = 1'b0;
      valid_gap = 1'b0;
      if (pc_enable) begin
        if (upd_q.size() == 0) begin
          check_eq("update_unexpected", pc_enable, 0);
        end else begin
          mon_e = upd_q.pop_front();
          check_eq("next_pc", next_pc, mon_e.tgt);
          check_eq("misaligned", misaligned_fetch, mon_e.mis);
          check_eq("instret", instret, mon_e.ret);
        end
        upd_gap = 1'b1;
      end
      if (instruction_valid) begin
        if (inst_q.size() == 0) begin
          check_eq("issue_unexpected", instruction_valid, 0);
        end else begin
          check_eq("instruction", instruction, inst_q.pop_front());
        end
        valid_gap = 1'b1;
      end
    end
  end

  task automatic clear_ctl();
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    trap_request  = 1'b0;
    trap_vector   = 32'd0;
    trap_return   = 1'b0;
    epc           = 32'd0;
    fetch_ack     = 1'b0;
    fetch_data    = 32'd0;
  endtask

  task automatic wait_fetch_req(output int at_cyc);
    int n = 0;
    while (fetch_req !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    at_cyc = cyc;
    if (fetch_req !== 1'b1) check_eq("fetch_req_timeout", fetch_req, 1);
  endtask

  // One instruction: fetch with fdly wait cycles, execute with xdly decoy cycles
  task automatic run_instr(input int fdly, input logic [31:0] word, input int xdly,
                           input logic br, input logic [31:0] bt,
                           input logic tr, input logic [31:0] tv,
                           input logic trr, input logic [31:0] ep,
                           input logic stray, output int fetch_cyc);
    int n;
    logic [31:0] tgt;
    logic mis, ret;
    wait_fetch_req(fetch_cyc);
    if (fetch_req !== 1'b1) return;
    check_eq("fetch_addr", fetch_addr, model_pc);
    if (stray) begin
      exec_done = 1'b1; trap_return = 1'b1; epc = 32'h0070_0000;
      trap_request = 1'b1; trap_vector = 32'h0077_0000;
    end
    repeat (fdly) @(negedge clock);
    clear_ctl();
    fetch_ack = 1'b1;
    fetch_data = word;
    inst_q.push_back(word);
    @(negedge clock);
    clear_ctl();
    n = 0;
    while (instruction_valid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (instruction_valid !== 1'b1) begin
      check_eq("issue_timeout", instruction_valid, 1);
      return;
    end
    @(negedge clock);
    repeat (xdly) begin
      trap_request = 1'b1; trap_vector = 32'h0BAD_0000;
      branch_taken = 1'b1; branch_target = 32'h0BAD_0004;
      fetch_ack = 1'b1; fetch_data = 32'hFFFF_0000;
      @(negedge clock);
    end
    clear_ctl();
    branch_taken = br; branch_target = bt;
    trap_request = tr; trap_vector = tv;
    trap_return = trr; epc = ep;
    exec_done = 1'b1;
    if (tr) begin
      tgt = tv; mis = 1'b0; ret = 1'b0;
    end else if (trr) begin
      if (ep[1:0] != 2'b00) begin tgt = tv; mis = 1'b1; ret = 1'b0; end
      else begin tgt = ep; mis = 1'b0; ret = 1'b1; end
    end else if (br) begin
      if (bt[1:0] != 2'b00) begin tgt = tv; mis = 1'b1; ret = 1'b0; end
      else begin tgt = bt; mis = 1'b0; ret = 1'b1; end
    end else begin
      tgt = model_pc + 32'd4; mis = 1'b0; ret = 1'b1;
    end
    model_pc  = tgt;
    model_ret = model_ret + {63'd0, ret};
    upd_q.push_back('{tgt, mis, model_ret});
    @(negedge clock);
    clear_ctl();
  endtask

  task automatic start_after_reset();
    reset     = 1'b1;
    model_pc  = INIT_PC;
    model_ret = 64'd0;
    upd_q.push_back('{INIT_PC, 1'b0, 64'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int f1, f2, f3, fx;
    reset  = 1'b0;
    pc_reg = 32'd0;
    clear_ctl();
    repeat (3) @(negedge clock);
    check_eq("rst_pc_enable", pc_enable, 0);
    check_eq("rst_fetch_req", fetch_req, 0);
    check_eq("rst_instruction", instruction, 0);
    check_eq("rst_valid", instruction_valid, 0);
    check_eq("rst_misaligned", misaligned_fetch, 0);
    check_eq("rst_instret", instret, 0);
    check_eq("rst_target", next_pc, INIT_PC);
    start_after_reset();

    run_instr(2, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, f1);
    run_instr(0, 32'h0000_0063, 0, 1, 32'h0040_0100, 1, 32'h0000_0200, 0, 0, 0, f2);
    run_instr(0, 32'h0000_0067, 0, 1, 32'h0040_0102, 0, 32'h0000_0300, 0, 0, 0, f3);
    check_eq("min_loop_latency", f3 - f2, 4);
    run_instr(1, 32'h0000_0073, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, fx);
    run_instr(0, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, fx);
    run_instr(2, 32'h3020_0073, 2, 0, 0, 0, 32'h0000_0400, 1, 32'h0040_0040, 1, fx);
    run_instr(0, 32'h3020_0073, 0, 0, 0, 0, 32'h0000_0500, 1, 32'h0000_0041, 0, fx);
    run_instr(3, 32'h0000_0fe3, 1, 1, 32'h0000_1000, 0, 0, 1, 32'h0040_0800, 0, fx);
    run_instr(0, 32'h0000_006f, 0, 1, 32'h0000_1000, 0, 0, 0, 0, 0, fx);

    // Reset arriving together with fetch_ack in FETCH
    wait_fetch_req(fx);
    reset = 1'b0;
    fetch_ack = 1'b1;
    fetch_data = 32'hDEAD_BEEF;
    @(negedge clock);
    clear_ctl();
    check_eq("rst_fetch_instruction", instruction, 0);
    check_eq("rst_fetch_valid", instruction_valid, 0);
    check_eq("rst_fetch_req_low", fetch_req, 0);
    check_eq("rst_fetch_instret", instret, 0);
    @(negedge clock);
    start_after_reset();
    repeat (2) begin
      @(negedge clock);
      check_eq("post_rst_no_issue", instruction_valid, 0);
    end
    run_instr(0, 32'h0000_0033, 0, 0, 0, 0, 0, 0, 0, 0, fx);

    repeat (3) @(negedge clock);
    check_eq("sb_update_drain", upd_q.size(), 0);
    check_eq("sb_issue_drain", inst_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
